// File: rtl/scie_fir_issuer.sv
// Command-side initiator for the SCIE FIR unit: turns coefficient and sample
// requests into COEF/PUSH/READ custom instructions and buffers the returned result.
module scie_fir_issuer #(
  parameter int XLEN     = 32,
  parameter int NTAPS    = 5,
  parameter int PIPE_LAT = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [XLEN-1:0] cfg_index,
  input  logic [XLEN-1:0] cfg_coeff,
  input  logic            smp_valid,
  output logic            smp_ready,
  input  logic [XLEN-1:0] smp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            scie_valid,
  output logic [XLEN-1:0] scie_insn,
  output logic [XLEN-1:0] scie_rs1,
  output logic [XLEN-1:0] scie_rs2,
  input  logic [XLEN-1:0] scie_rd,
  output logic            err
);

  localparam logic [XLEN-1:0] INSN_COEF = XLEN'(32'h0000_000B);
  localparam logic [XLEN-1:0] INSN_PUSH = XLEN'(32'h0000_002B);
  localparam logic [XLEN-1:0] INSN_READ = XLEN'(32'h0000_005B);
  localparam int CW = 3;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_COEF,
    ISSUE_PUSH,
    ISSUE_READ,
    WAIT,
    CAPTURE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            scie_valid_q, scie_valid_d;
  logic [XLEN-1:0] scie_insn_q, scie_insn_d;
  logic [XLEN-1:0] scie_rs1_q, scie_rs1_d;
  logic [XLEN-1:0] scie_rs2_q, scie_rs2_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_data_q, out_data_d;
  logic            err_q, err_d;

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    scie_valid_d = 1'b0;
    scie_insn_d  = '0;
    scie_rs1_d   = '0;
    scie_rs2_d   = '0;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    err_d        = err_q;

    // Readiness is gated by reset so nothing can handshake during the reset cycle.
    cfg_ready = (state_q == IDLE) && !reset;
    smp_ready = (state_q == IDLE) && !out_valid_q && !cfg_valid && !reset;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // The scie_* registers are loaded with the encoding of the state being entered.
    unique case (state_q)
      IDLE: begin
        if (cfg_valid && cfg_ready) begin
          if (cfg_index < XLEN'(NTAPS)) begin
            state_d      = ISSUE_COEF;
            scie_valid_d = 1'b1;
            scie_insn_d  = INSN_COEF;
            scie_rs1_d   = cfg_coeff;
            scie_rs2_d   = cfg_index;
          end else begin
            err_d = 1'b1;
          end
        end else if (smp_valid && smp_ready) begin
          state_d      = ISSUE_PUSH;
          scie_valid_d = 1'b1;
          scie_insn_d  = INSN_PUSH;
          scie_rs1_d   = smp_data;
        end
      end
      ISSUE_COEF: begin
        state_d = IDLE;
      end
      ISSUE_PUSH: begin
        state_d      = ISSUE_READ;
        scie_valid_d = 1'b1;
        scie_insn_d  = INSN_READ;
      end
      ISSUE_READ: begin
        if (PIPE_LAT == 1) begin
          state_d = CAPTURE;
        end else begin
          state_d    = WAIT;
          wait_cnt_d = CW'(PIPE_LAT - 1);
        end
      end
      WAIT: begin
        if (wait_cnt_q <= CW'(1)) begin
          state_d = CAPTURE;
        end else begin
          wait_cnt_d = wait_cnt_q - CW'(1);
        end
      end
      CAPTURE: begin
        out_valid_d = 1'b1;
        out_data_d  = scie_rd;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      scie_valid_q <= 1'b0;
      scie_insn_q  <= '0;
      scie_rs1_q   <= '0;
      scie_rs2_q   <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      scie_valid_q <= scie_valid_d;
      scie_insn_q  <= scie_insn_d;
      scie_rs1_q   <= scie_rs1_d;
      scie_rs2_q   <= scie_rs2_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      err_q        <= err_d;
    end
  end

  assign scie_valid = scie_valid_q;
  assign scie_insn  = scie_insn_q;
  assign scie_rs1   = scie_rs1_q;
  assign scie_rs2   = scie_rs2_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign err        = err_q;

endmodule

// File: tb/tb_scie_fir_issuer.sv
// Bench for scie_fir_issuer: two instances (PIPE_LAT 1 and 3) share one input
// stream and are each compared every cycle against a transaction-schedule model.
module tb_scie_fir_issuer;

  localparam int XLEN  = 32;
  localparam int NTAPS = 5;
  localparam int LAT0  = 1;
  localparam int LAT1  = 3;
  localparam logic [31:0] OP_COEF = 32'h0B;
  localparam logic [31:0] OP_PUSH = 32'h2B;
  localparam logic [31:0] OP_READ = 32'h5B;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic            reset;
  logic            cfg_valid;
  logic [XLEN-1:0] cfg_index;
  logic [XLEN-1:0] cfg_coeff;
  logic            smp_valid;
  logic [XLEN-1:0] smp_data;
  logic            out_ready;
  logic [XLEN-1:0] scie_rd_i [2];

  logic            cfg_ready_o  [2];
  logic            smp_ready_o  [2];
  logic            out_valid_o  [2];
  logic [XLEN-1:0] out_data_o   [2];
  logic            scie_valid_o [2];
  logic [XLEN-1:0] scie_insn_o  [2];
  logic [XLEN-1:0] scie_rs1_o   [2];
  logic [XLEN-1:0] scie_rs2_o   [2];
  logic            err_o        [2];

  scie_fir_issuer #(.XLEN(XLEN), .NTAPS(NTAPS), .PIPE_LAT(LAT0)) u_dut0 (
    .clock(clock), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_o[0]),
    .cfg_index(cfg_index), .cfg_coeff(cfg_coeff),
    .smp_valid(smp_valid), .smp_ready(smp_ready_o[0]), .smp_data(smp_data),
    .out_valid(out_valid_o[0]), .out_ready(out_ready), .out_data(out_data_o[0]),
    .scie_valid(scie_valid_o[0]), .scie_insn(scie_insn_o[0]),
    .scie_rs1(scie_rs1_o[0]), .scie_rs2(scie_rs2_o[0]),
    .scie_rd(scie_rd_i[0]), .err(err_o[0])
  );

  scie_fir_issuer #(.XLEN(XLEN), .NTAPS(NTAPS), .PIPE_LAT(LAT1)) u_dut1 (
    .clock(clock), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_o[1]),
    .cfg_index(cfg_index), .cfg_coeff(cfg_coeff),
    .smp_valid(smp_valid), .smp_ready(smp_ready_o[1]), .smp_data(smp_data),
    .out_valid(out_valid_o[1]), .out_ready(out_ready), .out_data(out_data_o[1]),
    .scie_valid(scie_valid_o[1]), .scie_insn(scie_insn_o[1]),
    .scie_rs1(scie_rs1_o[1]), .scie_rs2(scie_rs2_o[1]),
    .scie_rd(scie_rd_i[1]), .err(err_o[1])
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int lat [2];

  // Reference model: the cycle each instance becomes idle again, the scheduled
  // instruction per (cycle, instance), and the pending result buffer.
  int          free_at [2];
  int          cap_at  [2];
  logic [31:0] cap_val [2];
  bit          pend    [2];
  logic [31:0] pdata   [2];
  bit          err_m   [2];
  logic [95:0] ev_tab [int];

  // FIR-unit stub per instance: answers a READ exactly lat cycles later.
  logic [31:0] stub_smp [2];
  logic [31:0] stub_val [2];
  int          stub_cyc [2];

  function automatic logic [31:0] stub_result(input logic [31:0] s);
    if (s == 32'd54205) return 32'd124761;
    if (s == 32'd1234)  return 32'hDEAD_BEEF;
    return s * 32'd3 + 32'd7;
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s dut%0d cycle=%0d observed=%0h expected=%0h", tag, d, cyc, obs, exp);
    end
  endtask

  task automatic checkOutput(input int d);
    bit          idle;
    bit          ev_v;
    logic [95:0] e;
    idle = (cyc >= free_at[d]);
    ev_v = ev_tab.exists(cyc * 2 + d);
    e    = ev_v ? ev_tab[cyc * 2 + d] : 96'd0;
    chk("cfg_ready", d, 32'(cfg_ready_o[d]), 32'(idle && !reset));
    chk("smp_ready", d, 32'(smp_ready_o[d]), 32'(idle && !pend[d] && !cfg_valid && !reset));
    chk("scie_valid", d, 32'(scie_valid_o[d]), 32'(ev_v));
    chk("scie_insn", d, scie_insn_o[d], e[95:64]);
    chk("scie_rs1", d, scie_rs1_o[d], e[63:32]);
    chk("scie_rs2", d, scie_rs2_o[d], e[31:0]);
    chk("out_valid", d, 32'(out_valid_o[d]), 32'(pend[d]));
    chk("out_data", d, out_data_o[d], pdata[d]);
    chk("err", d, 32'(err_o[d]), 32'(err_m[d]));
    if (scie_valid_o[d] && scie_insn_o[d] == OP_PUSH) stub_smp[d] = scie_rs1_o[d];
    if (scie_valid_o[d] && scie_insn_o[d] == OP_READ) begin
      stub_cyc[d] = cyc + lat[d];
      stub_val[d] = stub_result(stub_smp[d]);
    end
  endtask

  task automatic modelStep(input int d);
    bit idle;
    bit pend0;
    idle  = (cyc >= free_at[d]);
    pend0 = pend[d];
    if (reset) begin
      free_at[d] = cyc + 1;
      cap_at[d]  = -1;
      pend[d]    = 1'b0;
      pdata[d]   = '0;
      err_m[d]   = 1'b0;
      ev_tab.delete((cyc + 1) * 2 + d);
      ev_tab.delete((cyc + 2) * 2 + d);
    end else begin
      if (pend0 && out_ready) pend[d] = 1'b0;
      if (cap_at[d] == cyc) begin
        pend[d]  = 1'b1;
        pdata[d] = cap_val[d];
      end
      if (idle && cfg_valid) begin
        if (cfg_index < NTAPS) begin
          ev_tab[(cyc + 1) * 2 + d] = {OP_COEF, cfg_coeff, cfg_index};
          free_at[d] = cyc + 2;
        end else begin
          err_m[d] = 1'b1;
        end
      end else if (idle && smp_valid && !pend0) begin
        ev_tab[(cyc + 1) * 2 + d] = {OP_PUSH, smp_data, 32'd0};
        ev_tab[(cyc + 2) * 2 + d] = {OP_READ, 32'd0, 32'd0};
        cap_at[d]  = cyc + 2 + lat[d];
        cap_val[d] = stub_result(smp_data);
        free_at[d] = cyc + 3 + lat[d];
      end
    end
  endtask

  // One clock cycle: drive inputs just after the edge, check and advance the model mid-cycle.
  task automatic applyStimulus(input bit rst, input bit cv, input logic [31:0] idx,
                               input logic [31:0] coeff, input bit sv,
                               input logic [31:0] sd, input bit ordy);
    @(posedge clock);
    cyc++;
    #1;
    reset     = rst;
    cfg_valid = cv;
    cfg_index = idx;
    cfg_coeff = coeff;
    smp_valid = sv;
    smp_data  = sd;
    out_ready = ordy;
    for (int d = 0; d < 2; d++) begin
      scie_rd_i[d] = (cyc == stub_cyc[d]) ? stub_val[d] : $urandom;
    end
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      checkOutput(d);
      modelStep(d);
    end
  endtask

  task automatic idleCycles(input int n, input bit ordy);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, ordy);
  endtask

  logic [31:0] coeffs [5];

  initial begin
    reset = 1'b1; cfg_valid = 1'b0; cfg_index = '0; cfg_coeff = '0;
    smp_valid = 1'b0; smp_data = '0; out_ready = 1'b0;
    lat[0] = LAT0; lat[1] = LAT1;
    for (int d = 0; d < 2; d++) begin
      scie_rd_i[d] = '0; free_at[d] = 0; cap_at[d] = -1; cap_val[d] = '0;
      pend[d] = 1'b0; pdata[d] = '0; err_m[d] = 1'b0;
      stub_smp[d] = '0; stub_val[d] = '0; stub_cyc[d] = -1;
    end
    coeffs[0] = 32'd45838; coeffs[1] = 32'd53395; coeffs[2] = 32'd65001;
    coeffs[3] = 32'd58774; coeffs[4] = 32'd7161;
    repeat (2) @(posedge clock);

    $display("[TB] reset state");
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 32'd5, 1, 32'd9, 0);

    $display("[TB] coefficient load 0..4 back to back");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, i, coeffs[i], 0, 0, 0);
      applyStimulus(0, 1, i, coeffs[i], 0, 0, 0);
    end

    $display("[TB] sample 54205 then backpressure with smp_valid held");
    applyStimulus(0, 0, 0, 0, 1, 32'd54205, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 1, 32'd999, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 32'd999, 1);
    idleCycles(8, 1);

    $display("[TB] cfg and smp together");
    applyStimulus(0, 1, 2, 32'd4242, 1, 32'd777, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 32'd777, 1);
    idleCycles(8, 1);

    $display("[TB] out-of-range index");
    applyStimulus(0, 1, 7, 32'd11, 0, 0, 1);
    idleCycles(3, 1);
    applyStimulus(0, 1, 4, 32'd12, 0, 0, 1);
    idleCycles(3, 1);

    $display("[TB] DEADBEEF result");
    applyStimulus(0, 0, 0, 0, 1, 32'd1234, 1);
    idleCycles(8, 0);
    idleCycles(2, 1);

    $display("[TB] reset during READ");
    applyStimulus(0, 0, 0, 0, 1, 32'd4321, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    idleCycles(8, 1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 59) == 0),
                    ($urandom_range(0, 3) == 0), $urandom_range(0, 7), $urandom,
                    ($urandom_range(0, 2) == 0), $urandom_range(0, 100000),
                    ($urandom_range(0, 1) == 1));
    end
    idleCycles(10, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
